// File: rtl/vga_object_engine_if.sv
// Config write bus for vga_object_engine: places, recolours, enables and sets
// the speed of one object per strobe.
interface vga_object_engine_if #(
  parameter int unsigned N_OBJ = 7,
  parameter int unsigned VEL_W = 4
);
  localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [9:0]       cfg_x;
  logic [9:0]       cfg_y;
  logic [VEL_W-1:0] cfg_vx;
  logic [VEL_W-1:0] cfg_vy;
  logic [23:0]      cfg_rgb;
  logic             cfg_on;

  modport master (output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy, cfg_rgb, cfg_on);
  modport slave  (input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy, cfg_rgb, cfg_on);
endinterface

// File: rtl/vga_object_engine.sv
// Multi-object square renderer: per-pixel priority hit test with registered RGB,
// plus a once-per-frame serial update pass that moves and bounces every object.
module vga_object_engine #(
  parameter int unsigned N_OBJ    = 7,
  parameter int unsigned OBJ_SIZE = 40,
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned VEL_W    = 4,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [9:0]              pixel_X_pos,
  input  logic [9:0]              pixel_Y_pos,
  input  logic                    pause,
  vga_object_engine_if.slave      cfg,
  output logic [7:0]              VGA_red,
  output logic [7:0]              VGA_green,
  output logic [7:0]              VGA_blue,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [9:0]  MAX_X = 10'(H_RES - OBJ_SIZE);
  localparam logic [9:0]  MAX_Y = 10'(V_RES - OBJ_SIZE);
  localparam logic [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  typedef struct packed {
    logic [9:0]       x;
    logic [9:0]       y;
    logic [VEL_W-1:0] vx;
    logic [VEL_W-1:0] vy;
    logic [23:0]      rgb;
    logic             on;
  } obj_t;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [23:0]      rgb_q;
  logic [23:0]      pix_rgb_c;
  logic             frame_trig_c;
  obj_t             obj_q [N_OBJ];
  obj_t             obj_d [N_OBJ];

  function automatic logic [9:0] clamp_pos(input logic [9:0] p, input logic [9:0] maxv);
    return (p > maxv) ? maxv : p;
  endfunction

  // The most negative velocity has no positive mirror, so bounce could not undo it.
  function automatic logic [VEL_W-1:0] sat_vel(input logic [VEL_W-1:0] v);
    return (v == VEL_MIN) ? VEL_MIN + VEL_W'(1) : v;
  endfunction

  // Returns {new_pos, new_vel} for one axis, bouncing off 0 and maxv.
  function automatic logic [9+VEL_W:0] step_axis(input logic [9:0] p,
                                                 input logic [VEL_W-1:0] v,
                                                 input logic [9:0] maxv);
    logic signed [11:0] n;
    n = $signed({2'b00, p}) + $signed({{(12-VEL_W){v[VEL_W-1]}}, v});
    if (n > $signed({2'b00, maxv})) return {maxv, VEL_W'(0) - v};
    else if (n[11])                 return {10'd0, VEL_W'(0) - v};
    else                            return {n[9:0], v};
  endfunction

  assign frame_trig_c = enable && !pause &&
                        (pixel_X_pos == 10'(H_RES - 1)) &&
                        (pixel_Y_pos == 10'(V_RES - 1));

  // Next object state: frame move first, then a same-cycle config write overrides it.
  always_comb begin
    obj_d = obj_q;
    for (int i = 0; i < N_OBJ; i++) begin
      if (state_q == S_UPDATE && idx_q == IDX_W'(i) && obj_q[i].on) begin
        {obj_d[i].x, obj_d[i].vx} = step_axis(obj_q[i].x, obj_q[i].vx, MAX_X);
        {obj_d[i].y, obj_d[i].vy} = step_axis(obj_q[i].y, obj_q[i].vy, MAX_Y);
      end
      if (cfg.cfg_we && cfg.cfg_idx == IDX_W'(i)) begin
        obj_d[i].x   = clamp_pos(cfg.cfg_x, MAX_X);
        obj_d[i].y   = clamp_pos(cfg.cfg_y, MAX_Y);
        obj_d[i].vx  = sat_vel(cfg.cfg_vx);
        obj_d[i].vy  = sat_vel(cfg.cfg_vy);
        obj_d[i].rgb = cfg.cfg_rgb;
        obj_d[i].on  = cfg.cfg_on;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_OBJ; i++) obj_q[i] <= '0;
    end else begin
      obj_q <= obj_d;
    end
  end

  // Descending scan so the lowest-index hit is the last one written.
  always_comb begin
    pix_rgb_c = BG_RGB;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (obj_q[i].on &&
          ({1'b0, pixel_X_pos} >= {1'b0, obj_q[i].x}) &&
          ({1'b0, pixel_X_pos} <  {1'b0, obj_q[i].x} + 11'(OBJ_SIZE)) &&
          ({1'b0, pixel_Y_pos} >= {1'b0, obj_q[i].y}) &&
          ({1'b0, pixel_Y_pos} <  {1'b0, obj_q[i].y} + 11'(OBJ_SIZE)))
        pix_rgb_c = obj_q[i].rgb;
    end
    if (pixel_X_pos >= 10'(H_RES) || pixel_Y_pos >= 10'(V_RES)) pix_rgb_c = BG_RGB;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     rgb_q <= BG_RGB;
    else if (enable) rgb_q <= pix_rgb_c;
  end

  // Update sequencer: one object per clock, then a single frame_done cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_done_q <= 1'b0;
          if (frame_trig_c) begin
            state_q <= S_UPDATE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (idx_q == IDX_W'(N_OBJ - 1)) begin
            state_q      <= S_DONE;
            idx_q        <= '0;
            frame_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          idx_q        <= '0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign VGA_red    = rgb_q[23:16];
  assign VGA_green  = rgb_q[15:8];
  assign VGA_blue   = rgb_q[7:0];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/vga_object_engine.md
# vga_object_engine

Parametrised multi-object renderer for the VGA path. It holds N_OBJ square objects, each with its own position, velocity, colour and enable, in registers. Each pixel it resolves the highest-priority object under the current coordinate and presents registered RGB to the VGA controller. Once per frame a serial update FSM moves every object by its velocity and bounces it off the screen edges. A config write port lets the top level or a controller place, recolour, enable and set the speed of each object.

## Interface
- N_OBJ, 7: number of objects, 1..16; index 0 has highest priority.
- OBJ_SIZE, 40: square side in pixels.
- H_RES, 640 / V_RES, 480: visible resolution.
- VEL_W, 4: signed velocity width, pixels/frame.
- BG_RGB, 24'h000000: background colour {R,G,B}.
- clock  in  1  50 MHz system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  pixel-rate qualifier, 25 MHz in a 50 MHz domain; all pixel-path registers advance only when it is 1.
- pixel_X_pos  in  10  current column from the VGA controller.
- pixel_Y_pos  in  10  current row from the VGA controller.
- pause  in  1  when 1, frame updates are skipped and objects freeze.
- cfg_we  in  1  one-cycle write strobe.
- cfg_idx  in  clog2(N_OBJ)  target object; writes with cfg_idx ≥ N_OBJ are ignored.
- cfg_x, cfg_y  in  10 each  new position, top-left corner.
- cfg_vx, cfg_vy  in  VEL_W each  signed velocity.
- cfg_rgb  in  24  object colour.
- cfg_on  in  1  object enable.
- VGA_red, VGA_green, VGA_blue  out  8 each  registered pixel colour.
- busy  out  1  high while the update FSM runs.
- frame_done  out  1  one-cycle pulse when an update pass completes.

## Operation
- Per-object state: x, y (10b), vx, vy (VEL_W signed), rgb (24b), on.
- Reset: every field is 0, all objects are off, RGB outputs are BG_RGB, busy=0, frame_done=0, FSM is in S_IDLE.
- Hit test for object i: on_i and x_i ≤ X < x_i+OBJ_SIZE and y_i ≤ Y < y_i+OBJ_SIZE. Comparisons are unsigned, 11 bits wide, with no wrap.
- Colour is the rgb of the lowest-index hitting object, or BG_RGB if no object hits. If X ≥ H_RES or Y ≥ V_RES, the colour is BG_RGB.
- Config write: the fields of object cfg_idx are loaded on the cycle cfg_we=1.
  - Positions are clamped: x to H_RES−OBJ_SIZE, y to V_RES−OBJ_SIZE.
  - A velocity of −2^(VEL_W−1) is stored as −(2^(VEL_W−1)−1).
- Update FSM states:
  - S_IDLE: go to S_UPDATE with idx=0 when enable=1, X=H_RES−1, Y=V_RES−1 and pause=0.
  - S_UPDATE: one object per clock, idx increments each cycle. After idx=N_OBJ−1, go to S_DONE.
  - S_DONE: frame_done=1 for one cycle, then return to S_IDLE.
  - busy=1 in S_UPDATE and S_DONE.
- Move rule, per axis, computed in 12-bit signed: n = p + v.
  - If n > MAX (MAX = H_RES−OBJ_SIZE or V_RES−OBJ_SIZE): p = MAX, v = −v.
  - Else if n < 0: p = 0, v = −v.
  - Else p = n.
  - Objects with on=0 are not moved.
- A config write to the object being updated in the same cycle wins; that object's move is discarded for this frame.
- Reset mid-update aborts the pass immediately and restores reset values.

## Timing
- Pixel path latency: RGB registered on the rising edge where enable=1 reflects pixel_X_pos/pixel_Y_pos sampled at that same edge. Exactly one register stage.
- With enable=0, the RGB outputs hold their value.
- Update pass: starts the clock after the trigger. S_UPDATE lasts N_OBJ clocks, then frame_done pulses on clock N_OBJ+1. The whole pass completes inside vertical blanking.
- Config writes take effect at the next clock and are visible to the pixel path on the next enable=1 edge.

## Test plan
- Reset then release, no writes: every pixel is 000000, busy=0.
- Write obj0 at (100,120), rgb FF0000, on. Drive X=100,Y=120 → FF0000. Drive X=140,Y=120 → BG. Drive X=99 → BG.
- Overlap: obj0 (300,220) FFFFFF and obj2 (320,230) 0000FF. Pixel (325,235) → FFFFFF. Pixel (345,235) → 0000FF.
- Motion and bounce: obj1 at (598,0) with vx=+5, vy=+3. After a frame trigger, read (600,3) and vx=−5. After the next trigger, read (595,6). frame_done asserts exactly N_OBJ+1 clocks after the trigger.
- pause=1 across two frame triggers: positions are unchanged and busy stays 0. cfg_vx=−8 with VEL_W=4 is stored as −7.
- Assert resetn low while busy=1 in S_UPDATE: busy=0 immediately and all objects are off. Config write to idx=N_OBJ: no state change.
